// File: rtl/fifo_cdc_pkg.sv
// Shared defaults and state encoding for the FIFO read-side byte unpacker.
package fifo_cdc_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_FLUSH_OUT = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_unpacker.sv
// Reads bytes from a FIFO read port (one-cycle read latency) and packs them
// into WORD_BYTES-wide words on a valid/ready stream, with flush of partial words.
module fifo_rd_unpacker
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                         clk_rd,
    input  logic                         reset_rd_n,
    input  logic                         empty,
    input  logic [DATA_W-1:0]            data_out,
    output logic                         rd_en,
    input  logic                         flush,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_W*WORD_BYTES-1:0] m_data,
    output logic [WORD_BYTES-1:0]        m_keep,
    output logic                         flush_done,
    output logic [15:0]                  word_count
);

    localparam int unsigned LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned CNT_W  = $clog2(WORD_BYTES) + 1;

    typedef logic [WORD_BYTES-1:0][DATA_W-1:0] word_t;

    rd_state_t        r_state;
    word_t            r_asm;
    logic [CNT_W-1:0] r_asm_cnt;
    logic             r_pend;
    word_t            r_m_data;
    logic [WORD_BYTES-1:0] r_m_keep;
    logic             r_m_valid;
    logic             r_flush_done;
    logic [15:0]      r_word_count;

    word_t                 w_asm_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [LANE_W-1:0]     w_lane;
    logic                  w_out_free;
    logic                  w_move;
    logic                  w_rd_en;
    logic [WORD_BYTES-1:0] w_keep;

    // Assembly view including the byte landing this cycle, and read issue.
    always_comb begin
        w_lane     = r_asm_cnt[LANE_W-1:0];
        w_asm_next = r_asm;
        if (r_pend) begin
            w_asm_next[w_lane] = data_out;
        end
        w_cnt_next = r_asm_cnt + CNT_W'(r_pend);
        w_out_free = !r_m_valid || m_ready;
        w_move     = (r_state == ST_FILL) && (w_cnt_next == CNT_W'(WORD_BYTES)) && w_out_free;
        // A word leaving this cycle frees lane 0, so read ahead to avoid a bubble.
        w_rd_en    = reset_rd_n && !empty && (r_state == ST_FILL) &&
                     ((w_cnt_next < CNT_W'(WORD_BYTES)) || w_move);
        w_keep     = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            w_keep[i] = (CNT_W'(i) < r_asm_cnt);
        end
    end

    always_ff @(posedge clk_rd) begin
        if (!reset_rd_n) begin
            r_state      <= ST_FILL;
            r_asm        <= '0;
            r_asm_cnt    <= '0;
            r_pend       <= 1'b0;
            r_m_data     <= '0;
            r_m_keep     <= '0;
            r_m_valid    <= 1'b0;
            r_flush_done <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_flush_done <= 1'b0;
            r_pend       <= w_rd_en;
            r_asm        <= w_asm_next;
            r_asm_cnt    <= w_cnt_next;

            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
                if (r_word_count != 16'hFFFF) begin
                    r_word_count <= r_word_count + 16'd1;
                end
            end

            case (r_state)
                ST_FILL: begin
                    if (w_move) begin
                        r_m_data  <= w_asm_next;
                        r_m_keep  <= '1;
                        r_m_valid <= 1'b1;
                        r_asm     <= '0;
                        r_asm_cnt <= '0;
                    end
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                // Let any in-flight read land before deciding what to emit.
                ST_DRAIN: begin
                    if (!r_pend) begin
                        if (r_asm_cnt != '0) begin
                            r_state <= ST_FLUSH_OUT;
                        end else begin
                            r_flush_done <= 1'b1;
                            r_state      <= ST_FILL;
                        end
                    end
                end
                ST_FLUSH_OUT: begin
                    if (w_out_free) begin
                        r_m_data     <= r_asm;
                        r_m_keep     <= w_keep;
                        r_m_valid    <= 1'b1;
                        r_asm        <= '0;
                        r_asm_cnt    <= '0;
                        r_flush_done <= 1'b1;
                        r_state      <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign rd_en      = w_rd_en;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_keep     = r_m_keep;
    assign flush_done = r_flush_done;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed and randomized checks of fifo_rd_unpacker against a FIFO model
// and a byte-stream reference queue.
module tb_fifo_rd_unpacker;

    logic        clk_rd     = 1'b0;
    logic        reset_rd_n = 1'b0;
    logic        empty      = 1'b1;
    logic [7:0]  data_out   = '0;
    logic        rd_en;
    logic        flush      = 1'b0;
    logic        m_valid;
    logic        m_ready    = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        flush_done;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  ref_q[$];
    logic [35:0] got_q[$];
    int          pop_cnt    = 0;
    logic        gate_empty = 1'b0;
    int          fd_cnt, rd_cycles, rd_run, rd_max;

    always #5 clk_rd = ~clk_rd;

    fifo_rd_unpacker dut (
        .clk_rd     (clk_rd),
        .reset_rd_n (reset_rd_n),
        .empty      (empty),
        .data_out   (data_out),
        .rd_en      (rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .flush_done (flush_done),
        .word_count (word_count)
    );

    // FIFO read port: data appears the cycle after an accepted read.
    always @(posedge clk_rd) begin
        if (rd_en && !empty) begin
            data_out <= fifo_q.pop_front();
            pop_cnt  <= pop_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_rd);
        empty = gate_empty || (fifo_q.size() == 0);
        #1;
        if (m_valid && m_ready) got_q.push_back({m_keep, m_data});
        if (flush_done) fd_cnt++;
        if (rd_en) begin
            rd_cycles++;
            rd_run++;
            if (rd_run > rd_max) rd_max = rd_run;
        end else begin
            rd_run = 0;
        end
        @(posedge clk_rd);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        ref_q.push_back(b);
    endtask

    task automatic take_word(input int n, output logic [35:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[i*8 +: 8] = ref_q.pop_front();
            w[32+i]     = 1'b1;
        end
    endtask

    task automatic check_next(input string tag, input logic [35:0] exp);
        logic [35:0] g;
        g = 'x;
        if (got_q.size() > 0) g = got_q.pop_front();
        check(tag, 64'(g), 64'(exp));
    endtask

    task automatic clear_stats();
        fd_cnt = 0; rd_cycles = 0; rd_run = 0; rd_max = 0;
        got_q.delete();
    endtask

    task automatic do_reset();
        reset_rd_n = 1'b0;
        step();
        step();
        reset_rd_n = 1'b1;
    endtask

    initial begin
        logic [35:0] e0, e1;
        int p0, guard;
        clear_stats();

        // Reset state
        do_reset();
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_m_keep_data", 64'({m_keep, m_data}), 64'd0);

        // Two full words with a ready sink
        clear_stats();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_byte(8'(i * 8'h11));
        repeat (14) step();
        check("basic_words", 64'(got_q.size()), 64'd2);
        check("basic_w0", 64'(got_q.size() > 0 ? got_q[0] : 36'hx), 64'h0F_4433_2211);
        check("basic_w1", 64'(got_q.size() > 1 ? got_q[1] : 36'hx), 64'h0F_8877_6655);
        void'(ref_q.size());
        ref_q.delete();
        check("basic_rd_cycles", 64'(rd_cycles), 64'd8);
        check("basic_rd_run", 64'(rd_max), 64'd8);
        check("basic_word_count", 64'(word_count), 64'd2);

        // Partial word flush
        clear_stats();
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        repeat (6) step();
        check("flush_hold_no_out", 64'(got_q.size()), 64'd0);
        flush = 1'b1; step(); flush = 1'b0;
        repeat (8) step();
        check("flush_words", 64'(got_q.size()), 64'd1);
        take_word(3, e0);
        check_next("flush_word", e0);
        check("flush_done_once", 64'(fd_cnt), 64'd1);

        // Flush with nothing buffered
        clear_stats();
        flush = 1'b1; step(); flush = 1'b0;
        repeat (8) step();
        check("empty_flush_words", 64'(got_q.size()), 64'd0);
        check("empty_flush_done", 64'(fd_cnt), 64'd1);
        check("empty_flush_count", 64'(word_count), 64'd3);

        // Backpressure: first word held, reads stop once both words are buffered
        clear_stats();
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
        take_word(4, e0);
        take_word(4, e1);
        repeat (6) step();
        for (int i = 0; i < 14; i++) begin
            check("stall_m_valid", 64'(m_valid), 64'd1);
            check("stall_word0", 64'({m_keep, m_data}), 64'(e0));
            step();
        end
        check("stall_rd_cycles", 64'(rd_cycles), 64'd8);
        check("stall_pops", 64'(pop_cnt - p0), 64'd8);
        check("stall_rd_low", 64'(rd_en), 64'd0);
        m_ready = 1'b1;
        repeat (6) step();
        check("stall_words", 64'(got_q.size()), 64'd2);
        check_next("stall_out0", e0);
        check_next("stall_out1", e1);

        // Gapped FIFO and random backpressure over 256 bytes
        do_reset();
        clear_stats();
        for (int i = 0; i < 256; i++) push_byte(8'($urandom_range(0, 255)));
        guard = 0;
        while (got_q.size() < 64 && guard < 4000) begin
            gate_empty = ~gate_empty;
            m_ready    = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        gate_empty = 1'b0;
        m_ready    = 1'b0;
        step();
        step();
        check("rand_timeout", 64'(guard < 4000), 64'd1);
        check("rand_words", 64'(got_q.size()), 64'd64);
        for (int i = 0; i < 64; i++) begin
            take_word(4, e0);
            check_next("rand_word", e0);
        end
        check("rand_word_count", 64'(word_count), 64'd64);

        // Reset with a partial word and a read in flight
        m_ready = 1'b1;
        clear_stats();
        ref_q.delete();
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
        repeat (3) step();
        check("mid_pops", 64'(pop_cnt - p0), 64'd3);
        reset_rd_n = 1'b0;
        step();
        check("rst_rd_en_forced", 64'(rd_en), 64'd0);
        step();
        check("rst_rd_en_forced2", 64'(rd_en), 64'd0);
        reset_rd_n = 1'b1;
        for (int i = 0; i < pop_cnt - p0; i++) ref_q.delete(0);
        check("post_rst_m_valid", 64'(m_valid), 64'd0);
        check("post_rst_word_count", 64'(word_count), 64'd0);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
        repeat (10) step();
        check("post_rst_words", 64'(got_q.size()), 64'd1);
        take_word(4, e0);
        check_next("post_rst_word", e0);
        check("post_rst_count", 64'(word_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
